// File: rtl/fmult_rr_sched_if.sv
// Requester-side bus of the shared multiplier scheduler.
// Requesters present operand pairs and receive results tagged with their index.
interface fmult_rr_sched_if #(
  parameter int NUM_REQ = 4,
  parameter int W       = 16,
  parameter int ID_W    = 2
);

  logic [NUM_REQ-1:0]   req_valid;
  logic [NUM_REQ-1:0]   req_ready;
  logic [NUM_REQ*W-1:0] req_a;
  logic [NUM_REQ*W-1:0] req_b;
  logic [NUM_REQ-1:0]   rsp_valid;
  logic [ID_W-1:0]      rsp_id;
  logic [W-1:0]         rsp_y;
  logic [2:0]           rsp_flag;

  modport master (
    output req_valid, req_a, req_b,
    input  req_ready, rsp_valid, rsp_id, rsp_y, rsp_flag
  );

  modport slave (
    input  req_valid, req_a, req_b,
    output req_ready, rsp_valid, rsp_id, rsp_y, rsp_flag
  );

endinterface

// File: rtl/fmult_rr_sched.sv
// Shares one fixed-latency half-precision multiplier between NUM_REQ requesters.
// Round-robin or fixed-priority grant, one issue per cycle, results routed back by id tag.
module fmult_rr_sched #(
  parameter int NUM_REQ  = 4,
  parameter int EXP      = 5,
  parameter int FRA      = 10,
  parameter int MULT_LAT = 0,
  localparam int W       = EXP + FRA + 1,
  localparam int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic               sys_clk,
  input  logic               sys_rst,
  input  logic               en,
  input  logic               prio_mode,
  fmult_rr_sched_if.slave    bus,
  output logic               mult_aresetn,
  output logic               mult_valid,
  output logic [W-1:0]       mult_a,
  output logic [W-1:0]       mult_b,
  input  logic [W-1:0]       mult_y,
  input  logic [2:0]         mult_flag,
  output logic               busy
);

  logic [ID_W-1:0]    ptr;
  logic [ID_W-1:0]    cand;
  logic [ID_W-1:0]    grant_id;
  logic               found;
  logic               take;
  logic [NUM_REQ-1:0] grant;
  logic [W-1:0]       a_arr [NUM_REQ];
  logic [W-1:0]       b_arr [NUM_REQ];
  logic [ID_W-1:0]    iss_id;
  logic               ret_valid;
  logic [ID_W-1:0]    ret_id;
  logic               tag_busy;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign a_arr[g] = bus.req_a[g*W +: W];
    assign b_arr[g] = bus.req_b[g*W +: W];
  end

  // Search starts just after the last winner in round-robin mode, at index 0 in fixed mode.
  always_comb begin
    cand     = '0;
    grant_id = '0;
    found    = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = prio_mode ? ID_W'(i) : ID_W'((int'(ptr) + 1 + i) % NUM_REQ);
      if (!found && bus.req_valid[cand]) begin
        found    = 1'b1;
        grant_id = cand;
      end
    end
  end

  assign take          = found & en & ~sys_rst;
  assign grant         = take ? (NUM_REQ'(1) << grant_id) : '0;
  assign bus.req_ready = grant;
  assign mult_aresetn  = ~sys_rst;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      ptr <= ID_W'(NUM_REQ - 1);
    end else if (take && !prio_mode) begin
      ptr <= grant_id;
    end
  end

  // Operands hold their last value on idle cycles; only the strobe drops.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      mult_valid <= 1'b0;
      mult_a     <= '0;
      mult_b     <= '0;
      iss_id     <= '0;
    end else begin
      mult_valid <= take;
      if (take) begin
        mult_a <= a_arr[grant_id];
        mult_b <= b_arr[grant_id];
        iss_id <= grant_id;
      end
    end
  end

  if (MULT_LAT == 0) begin : g_direct
    assign ret_valid = mult_valid;
    assign ret_id    = iss_id;
    assign tag_busy  = 1'b0;
  end else begin : g_pipe
    logic [MULT_LAT-1:0] tag_v;
    logic [ID_W-1:0]     tag_id [MULT_LAT];

    // Tags travel alongside the multiplier pipeline so the last stage lines up with mult_y.
    always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
        tag_v <= '0;
        for (int k = 0; k < MULT_LAT; k++) tag_id[k] <= '0;
      end else begin
        tag_v[0]  <= mult_valid;
        tag_id[0] <= iss_id;
        for (int k = 1; k < MULT_LAT; k++) begin
          tag_v[k]  <= tag_v[k-1];
          tag_id[k] <= tag_id[k-1];
        end
      end
    end

    assign ret_valid = tag_v[MULT_LAT-1];
    assign ret_id    = tag_id[MULT_LAT-1];
    assign tag_busy  = |tag_v;
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      bus.rsp_valid <= '0;
      bus.rsp_id    <= '0;
      bus.rsp_y     <= '0;
      bus.rsp_flag  <= '0;
    end else begin
      bus.rsp_valid <= ret_valid ? (NUM_REQ'(1) << ret_id) : '0;
      if (ret_valid) begin
        bus.rsp_id   <= ret_id;
        bus.rsp_y    <= mult_y;
        bus.rsp_flag <= mult_flag;
      end
    end
  end

  assign busy = mult_valid | tag_busy;

endmodule

// File: tb/tb_fmult_rr_sched.sv
// Directed bench for fmult_rr_sched: one combinational-multiplier instance and one 3-cycle
// instance share the same requester stimulus; each scenario checks the instance it targets.
module tb_fmult_rr_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        prio;
  logic [3:0]  req_valid;
  logic [63:0] req_a;
  logic [63:0] req_b;

  logic        m0_aresetn, m0_valid;
  logic [15:0] m0_a, m0_b, m0_y;
  logic [2:0]  m0_flag;
  logic        m0_busy;
  logic        m3_aresetn, m3_valid;
  logic [15:0] m3_a, m3_b, m3_y;
  logic [2:0]  m3_flag;
  logic        m3_busy;
  logic [18:0] p3 [3];

  logic [15:0] bval [4];
  logic [3:0]  rv0 [6], rv3 [6];
  logic        bz0 [6], bz3 [6];

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  fmult_rr_sched_if #(.NUM_REQ(4), .W(16), .ID_W(2)) bus0 ();
  fmult_rr_sched_if #(.NUM_REQ(4), .W(16), .ID_W(2)) bus3 ();

  assign bus0.req_valid = req_valid;
  assign bus0.req_a     = req_a;
  assign bus0.req_b     = req_b;
  assign bus3.req_valid = req_valid;
  assign bus3.req_a     = req_a;
  assign bus3.req_b     = req_b;

  fmult_rr_sched #(.NUM_REQ(4), .EXP(5), .FRA(10), .MULT_LAT(0)) dut0 (
    .sys_clk(clk), .sys_rst(rst), .en(en), .prio_mode(prio), .bus(bus0),
    .mult_aresetn(m0_aresetn), .mult_valid(m0_valid), .mult_a(m0_a), .mult_b(m0_b),
    .mult_y(m0_y), .mult_flag(m0_flag), .busy(m0_busy)
  );

  fmult_rr_sched #(.NUM_REQ(4), .EXP(5), .FRA(10), .MULT_LAT(3)) dut3 (
    .sys_clk(clk), .sys_rst(rst), .en(en), .prio_mode(prio), .bus(bus3),
    .mult_aresetn(m3_aresetn), .mult_valid(m3_valid), .mult_a(m3_a), .mult_b(m3_b),
    .mult_y(m3_y), .mult_flag(m3_flag), .busy(m3_busy)
  );

  // Reference half-precision multiply for normal operands, truncating; flag = {ovf, unf, inexact}.
  function automatic logic [18:0] fmul(input logic [15:0] a, input logic [15:0] b);
    logic        s;
    int          ea, eb, e;
    logic [21:0] p;
    logic [10:0] m;
    logic        inex;
    s  = a[15] ^ b[15];
    ea = int'(a[14:10]);
    eb = int'(b[14:10]);
    if (ea == 0 || eb == 0) return {3'b000, s, 15'h0000};
    p = {11'b0, 1'b1, a[9:0]} * {11'b0, 1'b1, b[9:0]};
    e = ea + eb - 15;
    if (p[21]) begin
      m    = p[21:11];
      inex = |p[10:0];
      e    = e + 1;
    end else begin
      m    = p[20:10];
      inex = |p[9:0];
    end
    if (e >= 31) return {3'b101, s, 5'h1f, 10'h000};
    if (e <= 0)  return {3'b011, s, 15'h0000};
    return {2'b00, inex, s, e[4:0], m[9:0]};
  endfunction

  assign {m0_flag, m0_y} = fmul(m0_a, m0_b);

  always @(posedge clk) begin
    p3[0] <= fmul(m3_a, m3_b);
    p3[1] <= p3[0];
    p3[2] <= p3[1];
  end
  assign {m3_flag, m3_y} = p3[2];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    req_valid = 4'b0000;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  // Every requester multiplies 1.0 by a distinct B, so each result equals that requester's B.
  task automatic load_ops();
    req_a = {4{16'h3c00}};
    req_b = {bval[3], bval[2], bval[1], bval[0]};
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; prio = 1'b0; req_valid = 4'b1111;
    load_ops();
    step();
    step();
    n_checks++; if (bus0.req_ready !== 4'b0000) $display("[TB] FAIL rst_ready: got %b want 0000", bus0.req_ready); else n_pass++;
    n_checks++; if (m0_valid !== 1'b0) $display("[TB] FAIL rst_mult_valid: got %b want 0", m0_valid); else n_pass++;
    n_checks++; if (m0_a !== 16'h0000) $display("[TB] FAIL rst_mult_a: got %h want 0000", m0_a); else n_pass++;
    n_checks++; if (bus0.rsp_valid !== 4'b0000) $display("[TB] FAIL rst_rsp_valid: got %b want 0000", bus0.rsp_valid); else n_pass++;
    n_checks++; if (bus0.rsp_y !== 16'h0000) $display("[TB] FAIL rst_rsp_y: got %h want 0000", bus0.rsp_y); else n_pass++;
    n_checks++; if (bus0.rsp_id !== 2'd0) $display("[TB] FAIL rst_rsp_id: got %0d want 0", bus0.rsp_id); else n_pass++;
    n_checks++; if (bus0.rsp_flag !== 3'b000) $display("[TB] FAIL rst_rsp_flag: got %b want 000", bus0.rsp_flag); else n_pass++;
    n_checks++; if (m0_busy !== 1'b0 || m3_busy !== 1'b0) $display("[TB] FAIL rst_busy: got %b%b want 00", m0_busy, m3_busy); else n_pass++;
    n_checks++; if (m0_aresetn !== 1'b0 || m3_aresetn !== 1'b0) $display("[TB] FAIL rst_aresetn: got %b%b want 00", m0_aresetn, m3_aresetn); else n_pass++;
    rst = 1'b0;
    req_valid = 4'b0000;
    #1;
    n_checks++; if (m0_aresetn !== 1'b1) $display("[TB] FAIL aresetn_release: got %b want 1", m0_aresetn); else n_pass++;
  endtask

  task automatic test_single_op();
    req_a = 64'h0; req_b = 64'h0;
    req_a[15:0] = 16'h3c00;
    req_b[15:0] = 16'h4000;
    req_valid = 4'b0001;
    #1;
    n_checks++; if (bus0.req_ready !== 4'b0001) $display("[TB] FAIL single_ready: got %b want 0001", bus0.req_ready); else n_pass++;
    step();
    req_valid = 4'b0000;
    n_checks++; if (m0_valid !== 1'b1 || m0_a !== 16'h3c00 || m0_b !== 16'h4000)
      $display("[TB] FAIL single_issue: got v=%b a=%h b=%h want 1 3c00 4000", m0_valid, m0_a, m0_b); else n_pass++;
    n_checks++; if (m0_busy !== 1'b1) $display("[TB] FAIL single_busy: got %b want 1", m0_busy); else n_pass++;
    n_checks++; if (bus0.rsp_valid !== 4'b0000) $display("[TB] FAIL single_early_rsp: got %b want 0000", bus0.rsp_valid); else n_pass++;
    step();
    n_checks++; if (bus0.rsp_valid !== 4'b0001) $display("[TB] FAIL single_rsp_valid: got %b want 0001", bus0.rsp_valid); else n_pass++;
    n_checks++; if (bus0.rsp_y !== 16'h4000) $display("[TB] FAIL single_rsp_y: got %h want 4000", bus0.rsp_y); else n_pass++;
    n_checks++; if (bus0.rsp_flag !== 3'b000 || bus0.rsp_id !== 2'd0)
      $display("[TB] FAIL single_rsp_tag: got flag=%b id=%0d want 000 0", bus0.rsp_flag, bus0.rsp_id); else n_pass++;
    n_checks++; if (m0_valid !== 1'b0 || m0_a !== 16'h3c00)
      $display("[TB] FAIL single_idle_hold: got v=%b a=%h want 0 3c00", m0_valid, m0_a); else n_pass++;
    n_checks++; if (m0_busy !== 1'b0) $display("[TB] FAIL single_busy_fall: got %b want 0", m0_busy); else n_pass++;
    step();
    n_checks++; if (bus0.rsp_valid !== 4'b0000 || bus0.rsp_y !== 16'h4000)
      $display("[TB] FAIL single_rsp_hold: got v=%b y=%h want 0000 4000", bus0.rsp_valid, bus0.rsp_y); else n_pass++;
    idle(6);
  endtask

  task automatic test_rr_fairness();
    logic [3:0]  exp_oh;
    logic [1:0]  exp_id;
    pulse_reset();
    load_ops();
    req_valid = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      #1;
      exp_oh = 4'b0001 << (k % 4);
      n_checks++; if (bus0.req_ready !== exp_oh) $display("[TB] FAIL rr_grant%0d: got %b want %b", k, bus0.req_ready, exp_oh); else n_pass++;
      if (k >= 2) begin
        exp_id = 2'((k - 2) % 4);
        exp_oh = 4'b0001 << exp_id;
        n_checks++; if (bus0.rsp_valid !== exp_oh || bus0.rsp_id !== exp_id || bus0.rsp_y !== bval[exp_id])
          $display("[TB] FAIL rr_rsp%0d: got v=%b id=%0d y=%h want %b %0d %h", k - 2, bus0.rsp_valid, bus0.rsp_id, bus0.rsp_y, exp_oh, exp_id, bval[exp_id]);
        else n_pass++;
      end
      step();
    end
    req_valid = 4'b0000;
    #1;
    n_checks++; if (bus0.rsp_id !== 2'd2 || bus0.rsp_y !== 16'h4200) $display("[TB] FAIL rr_rsp6: got id=%0d y=%h want 2 4200", bus0.rsp_id, bus0.rsp_y); else n_pass++;
    step();
    n_checks++; if (bus0.rsp_valid !== 4'b1000 || bus0.rsp_id !== 2'd3) $display("[TB] FAIL rr_rsp7: got v=%b id=%0d want 1000 3", bus0.rsp_valid, bus0.rsp_id); else n_pass++;
  endtask

  task automatic test_fixed_prio();
    prio = 1'b1;
    req_valid = 4'b1010;
    for (int k = 0; k < 4; k++) begin
      #1;
      n_checks++; if (bus0.req_ready !== 4'b0010) $display("[TB] FAIL fixed_grant%0d: got %b want 0010", k, bus0.req_ready); else n_pass++;
      if (k >= 2) begin
        n_checks++; if (bus0.rsp_valid !== 4'b0010 || bus0.rsp_y !== 16'h4100)
          $display("[TB] FAIL fixed_rsp%0d: got v=%b y=%h want 0010 4100", k - 2, bus0.rsp_valid, bus0.rsp_y); else n_pass++;
      end
      step();
    end
    // Pointer was left at 3 by the round-robin run; fixed mode must not have moved it.
    prio = 1'b0;
    req_valid = 4'b1111;
    #1;
    n_checks++; if (bus0.req_ready !== 4'b0001) $display("[TB] FAIL prio_ptr_kept: got %b want 0001", bus0.req_ready); else n_pass++;
    idle(6);
  endtask

  task automatic test_latency();
    req_a = 64'h0; req_b = 64'h0;
    req_a[47:32] = 16'h2e66;
    req_b[47:32] = 16'h2e66;
    req_valid = 4'b0100;
    #1;
    n_checks++; if (bus3.req_ready !== 4'b0100) $display("[TB] FAIL lat_ready: got %b want 0100", bus3.req_ready); else n_pass++;
    step();
    req_valid = 4'b0000;
    for (int s = 1; s <= 6; s++) begin
      if (s == 1) begin
        n_checks++; if (m3_valid !== 1'b1 || m3_a !== 16'h2e66) $display("[TB] FAIL lat_issue: got v=%b a=%h want 1 2e66", m3_valid, m3_a); else n_pass++;
      end
      n_checks++; if (bus3.rsp_valid !== ((s == 5) ? 4'b0100 : 4'b0000))
        $display("[TB] FAIL lat_rsp_valid_c%0d: got %b want %b", s, bus3.rsp_valid, (s == 5) ? 4'b0100 : 4'b0000); else n_pass++;
      n_checks++; if (m3_busy !== (s <= 4)) $display("[TB] FAIL lat_busy_c%0d: got %b want %b", s, m3_busy, (s <= 4)); else n_pass++;
      if (s == 5) begin
        n_checks++; if (bus3.rsp_y !== 16'h211e || bus3.rsp_flag !== 3'b001 || bus3.rsp_id !== 2'd2)
          $display("[TB] FAIL lat_result: got y=%h flag=%b id=%0d want 211e 001 2", bus3.rsp_y, bus3.rsp_flag, bus3.rsp_id); else n_pass++;
      end
      step();
    end
  endtask

  task automatic test_drain();
    rv3 = '{4'h0, 4'h1, 4'h2, 4'h4, 4'h8, 4'h0};
    bz3 = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    rv0 = '{4'h4, 4'h8, 4'h0, 4'h0, 4'h0, 4'h0};
    bz0 = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    pulse_reset();
    load_ops();
    en = 1'b1;
    req_valid = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      #1;
      n_checks++; if (bus3.req_ready !== (4'b0001 << k)) $display("[TB] FAIL drain_grant%0d: got %b want %b", k, bus3.req_ready, 4'b0001 << k); else n_pass++;
      step();
    end
    en = 1'b0;
    for (int s = 0; s < 6; s++) begin
      #1;
      n_checks++; if (bus0.req_ready !== 4'b0000 || bus3.req_ready !== 4'b0000)
        $display("[TB] FAIL drain_no_grant_c%0d: got %b %b want 0000", s, bus0.req_ready, bus3.req_ready); else n_pass++;
      n_checks++; if (bus3.rsp_valid !== rv3[s] || m3_busy !== bz3[s])
        $display("[TB] FAIL drain_lat3_c%0d: got v=%b busy=%b want %b %b", s, bus3.rsp_valid, m3_busy, rv3[s], bz3[s]); else n_pass++;
      n_checks++; if (bus0.rsp_valid !== rv0[s] || m0_busy !== bz0[s])
        $display("[TB] FAIL drain_lat0_c%0d: got v=%b busy=%b want %b %b", s, bus0.rsp_valid, m0_busy, rv0[s], bz0[s]); else n_pass++;
      if (s == 4) begin
        n_checks++; if (bus3.rsp_y !== 16'h4300) $display("[TB] FAIL drain_last_y: got %h want 4300", bus3.rsp_y); else n_pass++;
      end
      step();
    end
    en = 1'b1;
    idle(2);
  endtask

  task automatic test_reset_midflight();
    load_ops();
    req_valid = 4'b1111;
    for (int k = 0; k < 3; k++) begin
      #1;
      n_checks++; if (bus3.req_ready !== (4'b0001 << k)) $display("[TB] FAIL mid_grant%0d: got %b want %b", k, bus3.req_ready, 4'b0001 << k); else n_pass++;
      step();
    end
    rst = 1'b1;
    #1;
    n_checks++; if (bus3.req_ready !== 4'b0000) $display("[TB] FAIL mid_ready_in_rst: got %b want 0000", bus3.req_ready); else n_pass++;
    step();
    rst = 1'b0;
    #1;
    n_checks++; if (bus3.req_ready !== 4'b0001) $display("[TB] FAIL mid_next_grant: got %b want 0001", bus3.req_ready); else n_pass++;
    n_checks++; if (m3_busy !== 1'b0 || m3_valid !== 1'b0) $display("[TB] FAIL mid_cleared: got busy=%b v=%b want 0 0", m3_busy, m3_valid); else n_pass++;
    req_valid = 4'b0000;
    for (int s = 0; s < 6; s++) begin
      step();
      n_checks++; if (bus3.rsp_valid !== 4'b0000 || m3_busy !== 1'b0)
        $display("[TB] FAIL mid_discard_c%0d: got v=%b busy=%b want 0000 0", s, bus3.rsp_valid, m3_busy); else n_pass++;
    end
  endtask

  initial begin
    bval = '{16'h4000, 16'h4100, 16'h4200, 16'h4300};
    req_a = 64'h0;
    req_b = 64'h0;
    test_reset();
    test_single_op();
    test_rr_fairness();
    test_fixed_prio();
    test_latency();
    test_drain();
    test_reset_midflight();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout want completion");
    $fatal(1, "[TB] simulation did not complete");
  end

endmodule
